fan_ctrl: RTL and testbench

//  Closed-loop fan speed controller: per ADC sample, computes error = SET - ADC and runs
//  a 2nd-order IIR (discrete PID) to produce a saturated 0..255 control value.

---
 rtl/fan_ctrl_pkg.sv | 22 ++
 rtl/fan_ctrl_pwm.sv | 78 +++++++
 rtl/fan_ctrl.sv | 120 ++++++++++++
 tb/tb_fan_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_ctrl_pkg.sv
// fan_ctrl_pkg
//   Shared constants and helpers for the fan speed controller.
//   - Default widths: ADC 8 bits, coefficient 35 bits, of which 30 are fractional.
//   - sat_limit(): clamps a signed value into [0, 2^bits-1].
package fan_ctrl_pkg;

  localparam int ADC_BITWIDTH_DEF  = 8;
  localparam int REG_BITWIDTH_DEF  = 35;
  localparam int FRAC_BITWIDTH_DEF = 30;

  // Clamp to the unsigned range of a 'bits'-wide controller output.
  // The 64-bit argument covers the default accumulator width of 47 bits.
  function automatic logic signed [63:0] sat_limit(input logic signed [63:0] val,
                                                   input int unsigned        bits);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< bits) - 64'sd1;
    if (val < 64'sd0)   sat_limit = '0;
    else if (val > hi)  sat_limit = hi;
    else                sat_limit = val;
  endfunction

endpackage

// File: rtl/fan_ctrl_pwm.sv
// fan_ctrl_pwm
//   PWM generator: free-running tick counter, a duty latch that is reloaded
//   only when the counter wraps, and a registered compare output.
//   Ports:
//     clk_i, rstn_i     clock, synchronous active-low reset
//     clk_en_PWM_i      one counter tick per high cycle
//     period_i          PWM period in ticks (0 keeps the counter at 0)
//     min_i             minimum on-time in ticks
//     pid_val_i         controller output, non-negative
//     PWM_pin_o         registered PWM output
//   Build option: FANCTRL_PWM_INVERT_EN inverts the output (and resets it high).
module fan_ctrl_pwm #(
  parameter int CW = 9,          // counter / period width
  parameter int MW = 8           // minimum on-time width
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          clk_en_PWM_i,
  input  logic [CW-1:0] period_i,
  input  logic [MW-1:0] min_i,
  input  logic [CW-1:0] pid_val_i,
  output logic          PWM_pin_o
);

`ifdef FANCTRL_PWM_INVERT_EN
  localparam logic PIN_RST = 1'b1;
`else
  localparam logic PIN_RST = 1'b0;
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] duty_q, duty_d;
  logic          pin_q, pin_d;
  logic          wrap;
  logic [CW:0]   duty_sum;
  logic          active;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    cnt_d  = cnt_q;
    duty_d = duty_q;
    // A zero period wraps on every tick, which pins the counter at 0 and
    // reloads the duty with min(..., 0) = 0.
    wrap     = (period_i == '0) || (cnt_q >= period_i - CW'(1));
    // One extra bit so the sum cannot overflow before it is capped at the period.
    duty_sum = {{(CW + 1 - MW){1'b0}}, min_i} + {1'b0, pid_val_i};
    if (clk_en_PWM_i) begin
      if (wrap) begin
        cnt_d  = '0;
        duty_d = (duty_sum > {1'b0, period_i}) ? period_i : duty_sum[CW-1:0];
      end else begin
        cnt_d  = cnt_q + CW'(1);
      end
    end
    active = (cnt_q < duty_q);
`ifdef FANCTRL_PWM_INVERT_EN
    pin_d  = ~active;
`else
    pin_d  = active;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q  <= '0;
      duty_q <= {{(CW - MW){1'b0}}, min_i};
      pin_q  <= PIN_RST;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pin_q  <= pin_d;
    end
  end

  assign PWM_pin_o = pin_q;

endmodule

// File: rtl/fan_ctrl.sv
// fan_ctrl
//   Closed-loop fan speed controller. Each strobed ADC sample runs one step of
//   a 2nd-order IIR (discrete PID) on e = SET - ADC; the result is saturated
//   to 0..2^ADC_BITWIDTH-1 and fed to a PWM generator.
//   Ports:
//     clk_i, rstn_i          clock, synchronous active-low reset
//     clk_en_PWM_i           PWM tick enable
//     dataValid_STRB_i       one PID update per high cycle
//     periodCounterValue_i   PWM period in ticks
//     minCounterValue_i      minimum PWM on-time in ticks
//     ADC_value_i            measured value, unsigned
//     SET_value_i            setpoint, unsigned
//     a0_i, a1_i             signed feedback coefficients (Q(REG-FRAC).FRAC)
//     b0_i, b1_i, b2_i       signed feedforward coefficients
//     PWM_pin_o              fan PWM output, registered
//     PID_Val_o              signed controller output, 0..2^ADC_BITWIDTH-1
//   Build option: FANCTRL_PWM_INVERT_EN inverts the PWM output polarity.
module fan_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter int ADC_BITWIDTH  = ADC_BITWIDTH_DEF,
  parameter int REG_BITWIDTH  = REG_BITWIDTH_DEF,
  parameter int FRAC_BITWIDTH = FRAC_BITWIDTH_DEF
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           clk_en_PWM_i,
  input  logic                           dataValid_STRB_i,
  input  logic        [ADC_BITWIDTH:0]   periodCounterValue_i,
  input  logic        [ADC_BITWIDTH-1:0] minCounterValue_i,
  input  logic        [ADC_BITWIDTH-1:0] ADC_value_i,
  input  logic        [ADC_BITWIDTH-1:0] SET_value_i,
  input  logic signed [REG_BITWIDTH-1:0] a0_i,
  input  logic signed [REG_BITWIDTH-1:0] a1_i,
  input  logic signed [REG_BITWIDTH-1:0] b0_i,
  input  logic signed [REG_BITWIDTH-1:0] b1_i,
  input  logic signed [REG_BITWIDTH-1:0] b2_i,
  output logic                           PWM_pin_o,
  output logic signed [ADC_BITWIDTH:0]   PID_Val_o
);

  localparam int PW    = ADC_BITWIDTH + 1;
  // Five full-precision products of REG x (ADC+1) bits need 3 guard bits.
  localparam int ACC_W = REG_BITWIDTH + ADC_BITWIDTH + 4;

  logic signed [PW-1:0]    e;
  logic signed [PW-1:0]    e1_q, e1_d, e2_q, e2_d;
  logic signed [PW-1:0]    y1_q, y1_d, y2_q, y2_d;
  logic signed [PW-1:0]    pid_q, pid_d;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] y_shift;
  logic signed [PW-1:0]    y_sat;

  always_comb begin
    e1_d  = e1_q;
    e2_d  = e2_q;
    y1_d  = y1_q;
    y2_d  = y2_q;
    pid_d = pid_q;

    // Both operands zero-extended by one bit, so the difference always fits.
    e = $signed({1'b0, SET_value_i}) - $signed({1'b0, ADC_value_i});

    // Operands are sign-extended to the accumulator width before multiplying,
    // so every product is exact.
    acc = ACC_W'(b2_i) * ACC_W'(e)
        + ACC_W'(b1_i) * ACC_W'(e1_q)
        + ACC_W'(b0_i) * ACC_W'(e2_q)
        - ACC_W'(a1_i) * ACC_W'(y1_q)
        - ACC_W'(a0_i) * ACC_W'(y2_q);

    y_shift = acc >>> FRAC_BITWIDTH;
    y_sat   = PW'(sat_limit(64'(y_shift), ADC_BITWIDTH));

    if (dataValid_STRB_i) begin
      pid_d = y_sat;
      e2_d  = e1_q;
      e1_d  = e;
      // The history keeps the saturated output so the integrator cannot wind up.
      y2_d  = y1_q;
      y1_d  = y_sat;
    end
  end

  // NOTE: reset is sampled on the clock edge (synchronous), so it is tested
  // inside the clocked block rather than appearing in the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      e1_q  <= '0;
      e2_q  <= '0;
      y1_q  <= '0;
      y2_q  <= '0;
      pid_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so all registers update
      // together from values sampled before the edge.
      e1_q  <= e1_d;
      e2_q  <= e2_d;
      y1_q  <= y1_d;
      y2_q  <= y2_d;
      pid_q <= pid_d;
    end
  end

  assign PID_Val_o = pid_q;

  fan_ctrl_pwm #(
    .CW (PW),
    .MW (ADC_BITWIDTH)
  ) u_pwm (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .clk_en_PWM_i (clk_en_PWM_i),
    .period_i     (periodCounterValue_i),
    .min_i        (minCounterValue_i),
    .pid_val_i    (pid_q),
    .PWM_pin_o    (PWM_pin_o)
  );

endmodule

// File: tb/tb_fan_ctrl.sv
// tb_fan_ctrl
//   Directed and randomized bench for fan_ctrl. The PID reference is a plain
//   integer difference equation over Q30 coefficients; PWM duty is checked by
//   counting active cycles over one whole period. The closed-loop part drives
//   the ADC from a two-pole plant fed by the reference controller output.
module tb_fan_ctrl;

`ifdef FANCTRL_PWM_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rstn;
  logic               clk_en_pwm;
  logic               strobe;
  logic        [8:0]  period;
  logic        [7:0]  min_cnt;
  logic        [7:0]  adc;
  logic        [7:0]  setp;
  logic signed [34:0] a0, a1, b0, b1, b2;
  logic               pwm_pin;
  logic signed [8:0]  pid_val;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state: eh[0] current error, eh[1..2] past errors; yh[1..2] past outputs.
  longint bq[3];
  longint aq[3];
  int     eh[3];
  int     yh[3];

  always #5 clk = ~clk;

  fan_ctrl dut (
    .clk_i                (clk),
    .rstn_i               (rstn),
    .clk_en_PWM_i         (clk_en_pwm),
    .dataValid_STRB_i     (strobe),
    .periodCounterValue_i (period),
    .minCounterValue_i    (min_cnt),
    .ADC_value_i          (adc),
    .SET_value_i          (setp),
    .a0_i                 (a0),
    .a1_i                 (a1),
    .b0_i                 (b0),
    .b1_i                 (b1),
    .b2_i                 (b2),
    .PWM_pin_o            (pwm_pin),
    .PID_Val_o            (pid_val)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      eh[i] = 0;
      yh[i] = 0;
    end
  endfunction

  function automatic int model_step(input int err);
    longint acc;
    longint y;
    eh[2] = eh[1];
    eh[1] = eh[0];
    eh[0] = err;
    acc = bq[0] * eh[0] + bq[1] * eh[1] + bq[2] * eh[2] - aq[1] * yh[1] - aq[2] * yh[2];
    y = acc >>> 30;
    if (y < 0)   y = 0;
    if (y > 255) y = 255;
    yh[2] = yh[1];
    yh[1] = int'(y);
    return int'(y);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    model_reset();
    rstn = 1'b1;
  endtask

  // One strobed sample; returns the model's expected output after comparing it.
  task automatic strobe_once(input int s, input int a, input string tag, output int exp);
    setp   = 8'(s);
    adc    = 8'(a);
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    exp = model_step(s - a);
    check(tag, pid_val, exp);
  endtask

  task automatic measure_active(input int n, output int act);
    act = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      act += int'(pwm_pin ^ INV);
    end
  endtask

  initial begin
    int  exp;
    int  act;
    int  toggles;
    real x1, x2;
    int  a_int;

    rstn       = 1'b0;
    clk_en_pwm = 1'b1;
    strobe     = 1'b0;
    period     = 9'd320;
    min_cnt    = 8'd65;
    adc        = 8'd0;
    setp       = 8'd0;
    bq[0] = longint'(4.45858  * 1073741824.0);   // b2
    bq[1] = longint'(-8.88461 * 1073741824.0);   // b1
    bq[2] = longint'(4.42604  * 1073741824.0);   // b0
    aq[0] = 0;
    aq[1] = longint'(-1.92308 * 1073741824.0);   // a1
    aq[2] = longint'(0.92308  * 1073741824.0);   // a0
    b2 = 35'(bq[0]);
    b1 = 35'(bq[1]);
    b0 = 35'(bq[2]);
    a1 = 35'(aq[1]);
    a0 = 35'(aq[2]);
    model_reset();

    // Reset state
    tick();
    check("rst_pid", pid_val, 0);
    check("rst_pin", pwm_pin, INV);
    rstn = 1'b1;
    repeat (640) tick();
    measure_active(320, act);
    check("rst_duty_min", act, 65);

    // Step response
    do_reset();
    strobe_once(120, 100, "step1_model", exp);
    check("step1_const", pid_val, 89);
    strobe_once(120, 100, "step2_model", exp);
    check("step2_const", pid_val, 82);

    // No strobe: output holds, history verified by the next strobe
    for (int i = 0; i < 4; i++) begin
      repeat (25) tick();
      check("hold_pid", pid_val, 82);
    end
    strobe_once(120, 100, "after_hold", exp);

    // Negative error from reset clamps to zero; PWM stays at minimum
    do_reset();
    strobe_once(20, 100, "neg1_model", exp);
    check("neg1_const", pid_val, 0);
    repeat (640) tick();
    measure_active(320, act);
    check("neg_duty_min", act, 65);
    for (int i = 0; i < 4; i++) strobe_once(20, 100, "neg_model", exp);

    // Positive saturation: duty becomes the full period
    do_reset();
    strobe_once(255, 0, "sat_model", exp);
    check("sat_const", pid_val, 255);
    repeat (640) tick();
    measure_active(320, act);
    check("sat_duty_full", act, 320);

    // Reset while strobing: strobe ignored, everything clears
    strobe_once(200, 10, "pre_midrst", exp);
    rstn   = 1'b0;
    strobe = 1'b1;
    setp   = 8'd255;
    adc    = 8'd0;
    tick();
    strobe = 1'b0;
    model_reset();
    check("midrst_pid", pid_val, 0);
    check("midrst_pin", pwm_pin, INV);
    rstn = 1'b1;
    strobe_once(120, 100, "post_midrst", exp);
    check("post_midrst_const", pid_val, 89);

    // PWM enable low: pin frozen
    clk_en_pwm = 1'b0;
    tick();
    tick();
    act = int'(pwm_pin ^ INV);
    measure_active(50, toggles);
    check("en_low_frozen", toggles, act * 50);
    clk_en_pwm = 1'b1;

    // Period zero: output permanently inactive
    period = 9'd0;
    repeat (10) tick();
    measure_active(50, act);
    check("period0_low", act, 0);
    period = 9'd320;

    // Zero duty: min 0 with PID 0
    min_cnt = 8'd0;
    do_reset();
    repeat (10) tick();
    measure_active(400, act);
    check("duty0_low", act, 0);
    min_cnt = 8'd65;

    // Randomized samples with random gaps (including back-to-back)
    do_reset();
    for (int i = 0; i < 60; i++) begin
      strobe_once(int'($urandom_range(255)), int'($urandom_range(255)), "rand", exp);
      repeat ($urandom_range(3)) tick();
    end

    // Closed loop against a two-pole plant
    do_reset();
    x1 = 0.0;
    x2 = 0.0;
    a_int = 0;
    setp = 8'd210;
    toggles = 0;
    for (int i = 0; i < 300; i++) begin
      strobe_once(int'(setp), a_int, "loop_model", exp);
      check("loop_range", (pid_val >= 0 && pid_val <= 255), 1);
      x1 = x1 + 0.2 * (real'(exp) - x1);
      x2 = x2 + 0.2 * (x1 - x2);
      a_int = int'(x2);
      if (a_int < 0)   a_int = 0;
      if (a_int > 255) a_int = 255;
      if (setp == 8'd210 && a_int >= 200) begin
        setp = 8'd50;
        toggles++;
      end else if (setp == 8'd50 && a_int <= 50) begin
        setp = 8'd210;
        toggles++;
      end
      repeat ($urandom_range(3)) tick();
    end
    $display("closed loop setpoint toggles: %0d", toggles);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
